get_inverse_matrix: RTL and testbench



---
 rtl/get_inverse_matrix.sv | 173 +++++++++++++++++
 tb/tb_get_inverse_matrix.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/get_inverse_matrix.sv
// Final stage of the 2x2 Householder inverse: A^-1 = R^-1 * H1, using one shared
// restoring divider for 1/r11 and 1/r22 followed by a three-step multiply sequence.
module get_inverse_matrix #(
   parameter int FRAC = 16
) (
   input  logic               I_sys_clk,
   input  logic               I_sys_rst,
   input  logic               I_r_valid,
   input  logic signed [23:0] I_R11,
   input  logic signed [23:0] I_R12,
   input  logic signed [23:0] I_R21,
   input  logic signed [23:0] I_R22,
   input  logic signed [15:0] I_H11,
   input  logic signed [15:0] I_H12,
   input  logic signed [15:0] I_H21,
   input  logic signed [15:0] I_H22,
   output logic signed [31:0] O_inv11,
   output logic signed [31:0] O_inv12,
   output logic signed [31:0] O_inv21,
   output logic signed [31:0] O_inv22,
   output logic               O_valid,
   output logic               O_busy,
   output logic               O_singular,
   output logic               O_sat
);

   localparam int NIT = FRAC + 9;
   localparam int CW  = $clog2(NIT);

   typedef enum logic [2:0] {IDLE, DIV1, DIV2, MUL1, MUL2, MUL3} state_t;

   function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
      if (v > 64'sh0000_0000_7FFF_FFFF)      return 32'sh7FFF_FFFF;
      else if (v < 64'shFFFF_FFFF_8000_0000) return 32'sh8000_0000;
      else                                   return v[31:0];
   endfunction

   function automatic logic ovf32(input logic signed [63:0] v);
      return (v > 64'sh0000_0000_7FFF_FFFF) || (v < 64'shFFFF_FFFF_8000_0000);
   endfunction

   // |-2^23| must come out as 2^23, which the unsigned 24-bit result can hold
   function automatic logic [23:0] abs24(input logic signed [23:0] v);
      if (v[23]) return ~v + 24'd1;
      else       return v;
   endfunction

   state_t                   state_q;
   logic                     sing_pend_q;
   logic                     sat_q;
   logic [CW-1:0]            cnt_q;
   logic [NIT-1:0]           rem_q, quo_q, div_q;
   logic signed [23:0]       r11_q, r12_q, r22_q;
   logic signed [15:0]       h11_q, h12_q, h21_q, h22_q;
   logic signed [31:0]       d1_q, d2_q, t_q, rinv12_q;

   logic [NIT-1:0]           rem_sh_d, rem_d, quo_d;
   logic                     qbit_d, neg_d;
   logic signed [31:0]       q_ext_d, dres_d;
   logic signed [63:0]       p_t_d, p_r_d, s11_d, s12_d, s21_d, s22_d;
   logic                     unused_r21;

   assign unused_r21 = ^I_R21;

   // Dividend is 2^(FRAC+8): its only set bit enters on the first iteration
   always_comb begin
      rem_sh_d = {rem_q[NIT-2:0], (cnt_q == CW'(0))};
      if (rem_sh_d >= div_q) begin
         rem_d  = rem_sh_d - div_q;
         qbit_d = 1'b1;
      end else begin
         rem_d  = rem_sh_d;
         qbit_d = 1'b0;
      end
      quo_d   = {quo_q[NIT-2:0], qbit_d};
      neg_d   = (state_q == DIV1) ? r11_q[23] : r22_q[23];
      q_ext_d = 32'(quo_d);
      dres_d  = neg_d ? -q_ext_d : q_ext_d;
   end

   always_comb begin
      p_t_d = 64'(r12_q) * 64'(d2_q);
      p_r_d = -((64'(t_q) * 64'(d1_q)) >>> FRAC);
      s11_d = (64'(d1_q) * 64'(h11_q) + 64'(rinv12_q) * 64'(h21_q)) >>> 8;
      s12_d = (64'(d1_q) * 64'(h12_q) + 64'(rinv12_q) * 64'(h22_q)) >>> 8;
      s21_d = (64'(d2_q) * 64'(h21_q)) >>> 8;
      s22_d = (64'(d2_q) * 64'(h22_q)) >>> 8;
   end

   always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
      if (I_sys_rst) begin
         state_q <= IDLE;   sing_pend_q <= 1'b0; sat_q <= 1'b0;   cnt_q <= '0;
         rem_q <= '0;       quo_q <= '0;         div_q <= '0;
         r11_q <= '0;       r12_q <= '0;         r22_q <= '0;
         h11_q <= '0;       h12_q <= '0;         h21_q <= '0;     h22_q <= '0;
         d1_q <= '0;        d2_q <= '0;          t_q <= '0;       rinv12_q <= '0;
         O_inv11 <= '0;     O_inv12 <= '0;       O_inv21 <= '0;   O_inv22 <= '0;
         O_valid <= 1'b0;   O_busy <= 1'b0;      O_singular <= 1'b0; O_sat <= 1'b0;
      end else begin
         O_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sing_pend_q) begin
                  O_inv11 <= '0; O_inv12 <= '0; O_inv21 <= '0; O_inv22 <= '0;
                  O_singular  <= 1'b1;
                  O_sat       <= 1'b0;
                  O_valid     <= 1'b1;
                  sing_pend_q <= 1'b0;
               end else if (I_r_valid) begin
                  r11_q <= I_R11; r12_q <= I_R12; r22_q <= I_R22;
                  h11_q <= I_H11; h12_q <= I_H12; h21_q <= I_H21; h22_q <= I_H22;
                  sat_q <= 1'b0;
                  if ((I_R11 == 24'sd0) || (I_R22 == 24'sd0)) begin
                     sing_pend_q <= 1'b1;
                  end else begin
                     state_q <= DIV1;
                     O_busy  <= 1'b1;
                     cnt_q   <= '0;
                     rem_q   <= '0;
                     quo_q   <= '0;
                     div_q   <= NIT'(abs24(I_R11));
                  end
               end
            end
            DIV1: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(NIT - 1)) begin
                  d1_q    <= dres_d;
                  state_q <= DIV2;
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  div_q   <= NIT'(abs24(r22_q));
               end
            end
            DIV2: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(NIT - 1)) begin
                  d2_q    <= dres_d;
                  state_q <= MUL1;
               end
            end
            MUL1: begin
               t_q     <= sat32(p_t_d >>> 8);
               sat_q   <= sat_q | ovf32(p_t_d >>> 8);
               state_q <= MUL2;
            end
            MUL2: begin
               rinv12_q <= sat32(p_r_d);
               sat_q    <= sat_q | ovf32(p_r_d);
               state_q  <= MUL3;
            end
            MUL3: begin
               O_inv11    <= sat32(s11_d);
               O_inv12    <= sat32(s12_d);
               O_inv21    <= sat32(s21_d);
               O_inv22    <= sat32(s22_d);
               O_sat      <= sat_q | ovf32(s11_d) | ovf32(s12_d) | ovf32(s21_d) | ovf32(s22_d);
               O_singular <= 1'b0;
               O_valid    <= 1'b1;
               O_busy     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_get_inverse_matrix.sv
// Directed-vector bench for get_inverse_matrix: latency, results, singular,
// saturation, back-to-back acceptance and mid-job reset.
module tb_get_inverse_matrix;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               r_valid = 1'b0;
   logic signed [23:0] r11 = '0, r12 = '0, r21 = '0, r22 = '0;
   logic signed [15:0] h11 = '0, h12 = '0, h21 = '0, h22 = '0;
   logic signed [31:0] inv11, inv12, inv21, inv22;
   logic               o_valid, o_busy, o_sing, o_sat;
   int                 checks = 0;
   int                 errors = 0;

   get_inverse_matrix #(.FRAC(16)) dut (
      .I_sys_clk(clk), .I_sys_rst(rst), .I_r_valid(r_valid),
      .I_R11(r11), .I_R12(r12), .I_R21(r21), .I_R22(r22),
      .I_H11(h11), .I_H12(h12), .I_H21(h21), .I_H22(h22),
      .O_inv11(inv11), .O_inv12(inv12), .O_inv21(inv21), .O_inv22(inv22),
      .O_valid(o_valid), .O_busy(o_busy), .O_singular(o_sing), .O_sat(o_sat)
   );

   always #5 clk = ~clk;

   task automatic set_inputs(input int a11, input int a12, input int a22,
                             input int b11, input int b12, input int b21, input int b22);
      r11 = 24'(a11); r12 = 24'(a12); r22 = 24'(a22); r21 = 24'sd0;
      h11 = 16'(b11); h12 = 16'(b12); h21 = 16'(b21); h22 = 16'(b22);
   endtask

   // Leaves the bench 1 ns after the capture edge k
   task automatic start_job(input int a11, input int a12, input int a22,
                            input int b11, input int b12, input int b21, input int b22);
      @(negedge clk);
      set_inputs(a11, a12, a22, b11, b12, b21, b22);
      r_valid = 1'b1;
      @(posedge clk); #1;
      r_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!o_valid && n < 200);
   endtask

   task automatic test_reset;
      checks++;
      if ({inv11, inv12, inv21, inv22} !== 128'd0 || {o_valid, o_busy, o_sing, o_sat} !== 4'b0000) begin
         errors++;
         $display("FAIL reset: inv=%0d %0d %0d %0d flags(v,b,s,sat)=%b, want all zero",
                  inv11, inv12, inv21, inv22, {o_valid, o_busy, o_sing, o_sat});
      end
   endtask

   task automatic test_identity;
      int n;
      start_job(256, 0, 256, 256, 0, 0, 256);
      checks++;
      if (o_busy !== 1'b1) begin errors++; $display("FAIL identity_busy: got %b want 1", o_busy); end
      wait_valid(n);
      checks++;
      if (n !== 53) begin errors++; $display("FAIL identity_latency: got %0d want 53", n); end
      checks++;
      if (inv11 !== 32'sd65536 || inv12 !== 32'sd0 || inv21 !== 32'sd0 || inv22 !== 32'sd65536) begin
         errors++;
         $display("FAIL identity_inv: got %0d %0d %0d %0d want 65536 0 0 65536", inv11, inv12, inv21, inv22);
      end
      checks++;
      if ({o_busy, o_sing, o_sat} !== 3'b000) begin
         errors++; $display("FAIL identity_flags: got busy,sing,sat=%b want 000", {o_busy, o_sing, o_sat});
      end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0 || inv11 !== 32'sd65536) begin
         errors++; $display("FAIL identity_hold: valid=%b inv11=%0d want 0 65536", o_valid, inv11);
      end
   endtask

   task automatic test_backsub;
      int n;
      start_job(512, 256, 1024, 256, 0, 0, 256);
      wait_valid(n);
      checks++;
      if (n !== 53 || inv11 !== 32'sd32768 || inv12 !== -32'sd8192 || inv21 !== 32'sd0 || inv22 !== 32'sd16384) begin
         errors++;
         $display("FAIL backsub: n=%0d inv=%0d %0d %0d %0d want n=53 32768 -8192 0 16384",
                  n, inv11, inv12, inv21, inv22);
      end
   endtask

   task automatic test_negative;
      int n;
      start_job(-512, 0, 256, 0, 256, 256, 0);
      wait_valid(n);
      checks++;
      if (n !== 53 || inv11 !== 32'sd0 || inv12 !== -32'sd32768 || inv21 !== 32'sd65536 || inv22 !== 32'sd0) begin
         errors++;
         $display("FAIL negative: n=%0d inv=%0d %0d %0d %0d want n=53 0 -32768 65536 0",
                  n, inv11, inv12, inv21, inv22);
      end
   endtask

   // r11=r22=1 gives 2^24 reciprocals; r12=32768 overflows t, then rinv12
   task automatic test_saturation;
      int n;
      start_job(1, 32768, 1, 256, 0, 0, 256);
      wait_valid(n);
      checks++;
      if (inv11 !== 32'sd16777216 || inv12 !== 32'sh8000_0000 || inv21 !== 32'sd0 || inv22 !== 32'sd16777216) begin
         errors++;
         $display("FAIL sat_inv: got %0d %0d %0d %0d want 16777216 -2147483648 0 16777216",
                  inv11, inv12, inv21, inv22);
      end
      checks++;
      if (o_sat !== 1'b1 || o_sing !== 1'b0) begin
         errors++; $display("FAIL sat_flag: sat=%b sing=%b want 1 0", o_sat, o_sing);
      end
   endtask

   task automatic test_singular;
      logic seen_busy;
      start_job(256, 0, 0, 256, 0, 0, 256);
      seen_busy = o_busy;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL singular_early: valid=%b want 0", o_valid); end
      @(posedge clk); #1;
      seen_busy = seen_busy | o_busy;
      checks++;
      if (o_valid !== 1'b1 || {inv11, inv12, inv21, inv22} !== 128'd0 || o_sing !== 1'b1 || o_sat !== 1'b0) begin
         errors++;
         $display("FAIL singular: valid=%b inv=%0d %0d %0d %0d sing=%b sat=%b want 1, zeros, 1, 0",
                  o_valid, inv11, inv12, inv21, inv22, o_sing, o_sat);
      end
      @(posedge clk); #1;
      seen_busy = seen_busy | o_busy;
      checks++;
      if (seen_busy !== 1'b0 || o_valid !== 1'b0 || o_sing !== 1'b1) begin
         errors++;
         $display("FAIL singular_after: busy_seen=%b valid=%b sing=%b want 0 0 1", seen_busy, o_valid, o_sing);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      start_job(512, 256, 1024, 256, 0, 0, 256);
      repeat (10) @(posedge clk);
      #1;
      set_inputs(256, 0, 256, 256, 0, 0, 256);
      r_valid = 1'b1;
      @(posedge clk); #1;
      r_valid = 1'b0;
      wait_valid(n);
      checks++;
      if (n + 11 !== 53 || inv11 !== 32'sd32768 || inv12 !== -32'sd8192 || inv22 !== 32'sd16384) begin
         errors++;
         $display("FAIL b2b_ignore: latency=%0d inv=%0d %0d %0d want 53 32768 -8192 16384",
                  n + 11, inv11, inv12, inv22);
      end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_low: got %b want 0", o_busy); end
      r_valid = 1'b1;
      @(posedge clk); #1;
      r_valid = 1'b0;
      checks++;
      if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b want 1", o_busy); end
      wait_valid(n);
      checks++;
      if (n !== 53 || inv11 !== 32'sd65536 || inv12 !== 32'sd0 || inv22 !== 32'sd65536) begin
         errors++;
         $display("FAIL b2b_second: n=%0d inv=%0d %0d %0d want 53 65536 0 65536", n, inv11, inv12, inv22);
      end
   endtask

   task automatic test_reset_mid;
      int  n;
      logic seen;
      start_job(256, 0, 256, 256, 0, 0, 256);
      repeat (35) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({inv11, inv12, inv21, inv22} !== 128'd0 || {o_valid, o_busy, o_sing, o_sat} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid: inv11=%0d flags=%b want 0 0000", inv11, {o_valid, o_busy, o_sing, o_sat});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         seen = seen | o_valid;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_novalid: saw valid=%b want 0", seen); end
      start_job(256, 0, 256, 256, 0, 0, 256);
      wait_valid(n);
      checks++;
      if (n !== 53 || inv11 !== 32'sd65536 || inv12 !== 32'sd0 || inv21 !== 32'sd0 || inv22 !== 32'sd65536) begin
         errors++;
         $display("FAIL reset_mid_rerun: n=%0d inv=%0d %0d %0d %0d want 53 65536 0 0 65536",
                  n, inv11, inv12, inv21, inv22);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk);
      rst = 1'b0;
      test_identity;
      test_backsub;
      test_negative;
      test_saturation;
      test_singular;
      test_back_to_back;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
